// File: rtl/pr_hrav_pkg.sv
// Shared types and helpers for the HR-AV partial-reconfiguration sequencer.
package pr_hrav_pkg;

    localparam int unsigned PR_HRAV_MAX_CORES = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_PRE    = 3'd2,
        ST_CONFIG = 3'd3,
        ST_POST   = 3'd4,
        ST_ERR    = 3'd5
    } seq_state_t;

    // True when a requested core id addresses an existing core.
    function automatic logic id_in_range(input int unsigned id, input int unsigned n_cores);
        return (id < n_cores);
    endfunction

endpackage

// File: rtl/pr_hrav_core_reconfig_seq_if.sv
// Request and ICAP handshake bundle of the reconfiguration sequencer.
// master: software/ICAP side, slave: the sequencer.
interface pr_hrav_core_reconfig_seq_if #(
    parameter int unsigned CID_W = 4
) ();
    logic             req_valid;
    logic [CID_W-1:0] req_core_id;
    logic             req_ready;
    logic             cfg_start;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        output req_valid, req_core_id, cfg_done, cfg_err,
        input  req_ready, cfg_start
    );

    modport slave (
        input  req_valid, req_core_id, cfg_done, cfg_err,
        output req_ready, cfg_start
    );
endinterface

// File: rtl/pr_hrav_hold_timer.sv
// Loadable down-counter with zero flag; holds at zero.
module pr_hrav_hold_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] count_q;

    // Load takes priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pr_hrav_core_reconfig_seq.sv
// Per-core reconfiguration sequencer: drain, hold in reset around the ICAP
// bitstream write, then release and re-enable the target core.
// Optional macro PR_HRAV_DRAIN_TIMEOUT_EN: bounds DRAIN by DRAIN_TIMEOUT
// cycles and adds the sticky drain_to output.
module pr_hrav_core_reconfig_seq
    import pr_hrav_pkg::*;
#(
    parameter int unsigned N_CORES       = 2,
    parameter int unsigned CID_W         = 4,
    parameter int unsigned RST_PRE       = 4,
    parameter int unsigned RST_POST      = 16,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic               ACLK,
    input  logic               a_reset,
    input  logic [N_CORES-1:0] sw_core_rst,
    input  logic [N_CORES-1:0] sw_core_enb,
    input  logic [N_CORES-1:0] core_busy,
    pr_hrav_core_reconfig_seq_if.slave rbus,
    output logic [N_CORES-1:0] core_enb,
    output logic [N_CORES-1:0] core_rst,
    output logic               seq_done,
    output logic               seq_err,
    output logic [2:0]         seq_state,
    output logic [31:0]        reconfig_cnt,
    input  logic               clr_cnt
`ifdef PR_HRAV_DRAIN_TIMEOUT_EN
    ,
    output logic               drain_to
`endif
);

    if ((N_CORES < 1) || (N_CORES > PR_HRAV_MAX_CORES) || ((1 << CID_W) < N_CORES) ||
        (RST_PRE < 1) || (RST_PRE > 255) || (RST_POST < 1) || (RST_POST > 255) ||
        (DRAIN_TIMEOUT < 1)) begin : g_bad_cfg
        $error("pr_hrav_core_reconfig_seq: illegal parameter set");
    end

    seq_state_t         state_q, state_d;
    logic [CID_W-1:0]   cur_id_q, cur_id_d;
    logic [N_CORES-1:0] seq_rst_q, seq_rst_d;
    logic [N_CORES-1:0] seq_hold_q, seq_hold_d;
    logic [N_CORES-1:0] cur_mask, req_mask;
    logic [N_CORES-1:0] core_rst_q, core_enb_q;
    logic               hold_clr_q, hold_clr_d;
    logic               drain_arm_q, drain_arm_d;
    logic               req_ready_q;
    logic               cfg_start_q, cfg_start_d;
    logic               seq_done_q, seq_done_d;
    logic               seq_err_q, seq_err_d;
    logic [31:0]        cnt_q;
    logic               hs, id_ok, cur_busy;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [7:0]         tmr_val;
    logic               to_zero;
    logic               to_set;

    assign hs    = rbus.req_valid & req_ready_q;
    assign id_ok = id_in_range(32'(rbus.req_core_id), N_CORES);

    // One-hot masks of the latched and the requested core id.
    always_comb begin
        cur_mask = '0;
        req_mask = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (cur_id_q == CID_W'(i))         cur_mask[i] = 1'b1;
            if (rbus.req_core_id == CID_W'(i)) req_mask[i] = 1'b1;
        end
        cur_busy = |(core_busy & cur_mask);
    end

    pr_hrav_hold_timer #(.W(8)) u_hold_timer (
        .clk_i      (ACLK),
        .rst_i      (a_reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

`ifdef PR_HRAV_DRAIN_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(DRAIN_TIMEOUT + 1);
    logic drain_to_q;

    pr_hrav_hold_timer #(.W(TO_W)) u_drain_timer (
        .clk_i      (ACLK),
        .rst_i      (a_reset),
        .load_i     (hs & id_ok),
        .load_val_i (TO_W'(DRAIN_TIMEOUT - 1)),
        .dec_i      (state_q == ST_DRAIN),
        .zero_o     (to_zero)
    );

    assign drain_to = drain_to_q;
`else
    assign to_zero = 1'b0;
`endif

    // Next-state, per-core reset/hold masks and pulse requests.
    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        seq_rst_d   = seq_rst_q;
        seq_hold_d  = seq_hold_q;
        hold_clr_d  = 1'b0;
        drain_arm_d = drain_arm_q;
        cfg_start_d = 1'b0;
        seq_done_d  = 1'b0;
        seq_err_d   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;
        to_set      = 1'b0;

        // Delayed hold release is applied before a new handshake can set a
        // bit, so an immediate re-request of the same core keeps it held.
        if (hold_clr_q) seq_hold_d = seq_hold_d & ~cur_mask;

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    if (!id_ok) begin
                        seq_err_d = 1'b1;
                    end else begin
                        cur_id_d    = rbus.req_core_id;
                        seq_hold_d  = seq_hold_d | req_mask;
                        drain_arm_d = 1'b0;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_arm_d = 1'b1;
                if ((drain_arm_q && !cur_busy) || to_zero) begin
                    to_set    = to_zero & cur_busy;
                    seq_rst_d = seq_rst_d | cur_mask;
                    tmr_load  = 1'b1;
                    tmr_val   = 8'(RST_PRE - 1);
                    state_d   = ST_PRE;
                end
            end
            ST_PRE: begin
                if (tmr_zero) begin
                    cfg_start_d = 1'b1;
                    state_d     = ST_CONFIG;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_CONFIG: begin
                if (rbus.cfg_err) begin
                    state_d = ST_ERR;
                end else if (rbus.cfg_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = 8'(RST_POST - 1);
                    state_d  = ST_POST;
                end
            end
            ST_POST: begin
                if (tmr_zero) begin
                    seq_rst_d  = seq_rst_d & ~cur_mask;
                    hold_clr_d = 1'b1;
                    seq_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ERR: begin
                seq_err_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, registered outputs and completion counter.
    always_ff @(posedge ACLK) begin
        if (a_reset) begin
            state_q     <= ST_IDLE;
            cur_id_q    <= '0;
            seq_rst_q   <= '0;
            seq_hold_q  <= '0;
            hold_clr_q  <= 1'b0;
            drain_arm_q <= 1'b0;
            req_ready_q <= 1'b0;
            cfg_start_q <= 1'b0;
            seq_done_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            core_rst_q  <= '1;
            core_enb_q  <= '0;
            cnt_q       <= '0;
`ifdef PR_HRAV_DRAIN_TIMEOUT_EN
            drain_to_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            seq_rst_q   <= seq_rst_d;
            seq_hold_q  <= seq_hold_d;
            hold_clr_q  <= hold_clr_d;
            drain_arm_q <= drain_arm_d;
            req_ready_q <= (state_d == ST_IDLE);
            cfg_start_q <= cfg_start_d;
            seq_done_q  <= seq_done_d;
            seq_err_q   <= seq_err_d;
            core_rst_q  <= sw_core_rst | seq_rst_d;
            core_enb_q  <= sw_core_enb & ~seq_hold_d;
            if (clr_cnt)         cnt_q <= '0;
            else if (seq_done_d) cnt_q <= cnt_q + 32'd1;
`ifdef PR_HRAV_DRAIN_TIMEOUT_EN
            if (clr_cnt)     drain_to_q <= 1'b0;
            else if (to_set) drain_to_q <= 1'b1;
`endif
        end
    end

    assign rbus.req_ready = req_ready_q;
    assign rbus.cfg_start = cfg_start_q;
    assign core_rst       = core_rst_q;
    assign core_enb       = core_enb_q;
    assign seq_done       = seq_done_q;
    assign seq_err        = seq_err_q;
    assign seq_state      = state_q;
    assign reconfig_cnt   = cnt_q;

endmodule

// File: tb/tb_pr_hrav_core_reconfig_seq.sv
// Scoreboard bench for pr_hrav_core_reconfig_seq (N_CORES=2, RST_PRE=4, RST_POST=16).
// Define PR_HRAV_DRAIN_TIMEOUT_EN to also exercise the drain timeout (DRAIN_TIMEOUT=32).
module tb_pr_hrav_core_reconfig_seq;

    typedef struct {
        logic [2:0]  kind;   // {seq_err, seq_done, cfg_start}
        int          cyc;
        logic [2:0]  st;
        logic [1:0]  rst;
        logic [1:0]  enb;
        logic [31:0] cnt;
    } exp_t;

    logic        ACLK;
    logic        a_reset;
    logic [1:0]  sw_core_rst, sw_core_enb, core_busy;
    logic [1:0]  core_enb, core_rst;
    logic        seq_done, seq_err, clr_cnt;
    logic [2:0]  seq_state;
    logic [31:0] reconfig_cnt;
`ifdef PR_HRAV_DRAIN_TIMEOUT_EN
    logic        drain_to;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    logic track0 = 1'b0;
    logic core0_bad = 1'b0;
    int   n, s, hold;

    pr_hrav_core_reconfig_seq_if #(.CID_W(4)) rbus ();

    pr_hrav_core_reconfig_seq #(
        .N_CORES(2), .CID_W(4), .RST_PRE(4), .RST_POST(16), .DRAIN_TIMEOUT(32)
    ) dut (
        .ACLK(ACLK), .a_reset(a_reset), .sw_core_rst(sw_core_rst), .sw_core_enb(sw_core_enb),
        .core_busy(core_busy), .rbus(rbus.slave), .core_enb(core_enb), .core_rst(core_rst),
        .seq_done(seq_done), .seq_err(seq_err), .seq_state(seq_state),
        .reconfig_cnt(reconfig_cnt), .clr_cnt(clr_cnt)
`ifdef PR_HRAV_DRAIN_TIMEOUT_EN
        , .drain_to(drain_to)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [2:0] k, input int c, input logic [2:0] st,
                            input logic [1:0] r, input logic [1:0] e, input logic [31:0] cnt);
        exp_t x;
        x.kind = k; x.cyc = c; x.st = st; x.rst = r; x.enb = e; x.cnt = cnt;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    // Bounded wait for cfg_start (which=0) or seq_done (which=1).
    task automatic wait_evt(input int which, input int max_cyc);
        int k = 0;
        while (((which == 0) ? rbus.cfg_start : seq_done) !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
        chk((which == 0) ? "wait_cfg_start" : "wait_seq_done",
            {31'd0, ((which == 0) ? rbus.cfg_start : seq_done)}, 32'd1);
    endtask

    // Scoreboard monitor: every output pulse must match the head of the queue.
    always @(negedge ACLK) begin
        if (rbus.cfg_start === 1'b1 || seq_done === 1'b1 || seq_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {29'd0, seq_err, seq_done, rbus.cfg_start}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("evt_kind", {29'd0, seq_err, seq_done, rbus.cfg_start}, {29'd0, e.kind});
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_state", {29'd0, seq_state}, {29'd0, e.st});
                chk("evt_core_rst", {30'd0, core_rst}, {30'd0, e.rst});
                chk("evt_core_enb", {30'd0, core_enb}, {30'd0, e.enb});
                chk("evt_cnt", reconfig_cnt, e.cnt);
            end
        end
    end

    always @(negedge ACLK) begin
        if (track0 && (core_rst[0] !== 1'b0 || core_enb[0] !== 1'b1)) core0_bad <= 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset = 1'b1; sw_core_rst = 2'b00; sw_core_enb = 2'b11; core_busy = 2'b00;
        rbus.req_valid = 1'b0; rbus.req_core_id = 4'd0; rbus.cfg_done = 1'b0;
        rbus.cfg_err = 1'b0; clr_cnt = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_core_rst", {30'd0, core_rst}, 32'h3);
        chk("rst_core_enb", {30'd0, core_enb}, 32'h0);
        chk("rst_req_ready", {31'd0, rbus.req_ready}, 32'd0);
        chk("rst_pulses", {29'd0, seq_err, seq_done, rbus.cfg_start}, 32'd0);
        chk("rst_state", {29'd0, seq_state}, 32'd0);
        chk("rst_cnt", reconfig_cnt, 32'd0);
`ifdef PR_HRAV_DRAIN_TIMEOUT_EN
        chk("rst_drain_to", {31'd0, drain_to}, 32'd0);
`endif
        a_reset = 1'b0;
        tick();
        chk("rel_core_rst", {30'd0, core_rst}, 32'h0);
        chk("rel_core_enb", {30'd0, core_enb}, 32'h3);
        chk("rel_req_ready", {31'd0, rbus.req_ready}, 32'd1);

        // Software controls pass through with one cycle latency
        sw_core_rst = 2'b01; sw_core_enb = 2'b10;
        tick();
        chk("sw_core_rst", {30'd0, core_rst}, 32'h1);
        chk("sw_core_enb", {30'd0, core_enb}, 32'h2);
        sw_core_rst = 2'b00; sw_core_enb = 2'b11;
        tick();
        chk("sw_restore", {28'd0, core_rst, core_enb}, 32'h3);

        // Request core 1, busy for 10 cycles; stray cfg_err while draining
        track0 = 1'b1;
        core_busy = 2'b10; rbus.req_valid = 1'b1; rbus.req_core_id = 4'd1;
        tick();
        rbus.req_valid = 1'b0; n = cyc;
        chk("hs_core_enb", {30'd0, core_enb}, 32'h1);
        chk("hs_state_drain", {29'd0, seq_state}, 32'd1);
        chk("hs_req_ready", {31'd0, rbus.req_ready}, 32'd0);
        repeat (3) tick();
        rbus.cfg_err = 1'b1;
        tick();
        rbus.cfg_err = 1'b0;
        repeat (5) tick();
        chk("drain_no_rst", {30'd0, core_rst}, 32'h0);
        chk("drain_ignores_err", {29'd0, seq_state}, 32'd1);
        core_busy = 2'b00;
        push_exp(3'b001, n + 14, 3'd3, 2'b10, 2'b01, 32'd0);
        tick();
        chk("pre_core_rst", {30'd0, core_rst}, 32'h2);
        chk("pre_state", {29'd0, seq_state}, 32'd2);
        wait_evt(0, 10);
        rbus.cfg_done = 1'b1;
        tick();
        rbus.cfg_done = 1'b0; s = cyc;
        chk("post_state", {29'd0, seq_state}, 32'd4);
        push_exp(3'b010, s + 16, 3'd0, 2'b00, 2'b01, 32'd1);
        hold = 0;
        while (core_rst[1] === 1'b1 && hold < 40) begin
            hold++;
            tick();
        end
        chk("post_hold_cycles", hold, 32'd16);
        chk("enb_still_low", {30'd0, core_enb}, 32'h1);
        tick();
        chk("enb_returns", {30'd0, core_enb}, 32'h3);
        track0 = 1'b0;
        chk("core0_untouched", {31'd0, core0_bad}, 32'd0);

        // Out-of-range id
        rbus.req_valid = 1'b1; rbus.req_core_id = 4'd3;
        push_exp(3'b100, cyc + 1, 3'd0, 2'b00, 2'b11, 32'd1);
        tick();
        rbus.req_valid = 1'b0;
        chk("badid_ready", {31'd0, rbus.req_ready}, 32'd1);
        tick();
        chk("badid_single_pulse", {31'd0, seq_err}, 32'd0);
        chk("badid_outputs", {28'd0, core_rst, core_enb}, 32'h3);

        // cfg_err and cfg_done together on core 0
        rbus.req_valid = 1'b1; rbus.req_core_id = 4'd0; n = cyc;
        push_exp(3'b001, n + 7, 3'd3, 2'b01, 2'b10, 32'd1);
        tick();
        rbus.req_valid = 1'b0;
        wait_evt(0, 12);
        s = cyc;
        rbus.cfg_done = 1'b1; rbus.cfg_err = 1'b1;
        push_exp(3'b100, s + 2, 3'd0, 2'b01, 2'b10, 32'd1);
        tick();
        rbus.cfg_done = 1'b0; rbus.cfg_err = 1'b0;
        chk("err_state", {29'd0, seq_state}, 32'd5);
        repeat (4) tick();
        chk("err_keeps_core", {28'd0, core_rst, core_enb}, 32'h6);
        chk("err_cnt", reconfig_cnt, 32'd1);

        // Retry core 0
        rbus.req_valid = 1'b1; rbus.req_core_id = 4'd0; n = cyc;
        push_exp(3'b001, n + 7, 3'd3, 2'b01, 2'b10, 32'd1);
        tick();
        rbus.req_valid = 1'b0;
        wait_evt(0, 12);
        s = cyc;
        rbus.cfg_done = 1'b1;
        push_exp(3'b010, s + 17, 3'd0, 2'b00, 2'b10, 32'd2);
        tick();
        rbus.cfg_done = 1'b0;
        wait_evt(1, 25);
        tick();
        chk("retry_enb", {30'd0, core_enb}, 32'h3);

        // Reset asserted during POST
        rbus.req_valid = 1'b1; rbus.req_core_id = 4'd1; n = cyc;
        push_exp(3'b001, n + 7, 3'd3, 2'b10, 2'b01, 32'd2);
        tick();
        rbus.req_valid = 1'b0;
        wait_evt(0, 12);
        rbus.cfg_done = 1'b1;
        tick();
        rbus.cfg_done = 1'b0;
        tick();
        a_reset = 1'b1;
        tick();
        chk("mid_rst_core", {28'd0, core_rst, core_enb}, 32'hC);
        chk("mid_rst_state", {29'd0, seq_state}, 32'd0);
        chk("mid_rst_cnt", reconfig_cnt, 32'd0);
        chk("mid_rst_ready", {28'd0, rbus.req_ready, seq_err, seq_done, rbus.cfg_start}, 32'd0);
        a_reset = 1'b0;
        tick();
        chk("mid_rst_release", {28'd0, core_rst, core_enb}, 32'h3);

        // clr_cnt wins over a simultaneous increment
        rbus.req_valid = 1'b1; rbus.req_core_id = 4'd1; n = cyc;
        push_exp(3'b001, n + 7, 3'd3, 2'b10, 2'b01, 32'd0);
        tick();
        rbus.req_valid = 1'b0;
        wait_evt(0, 12);
        s = cyc;
        rbus.cfg_done = 1'b1;
        push_exp(3'b010, s + 17, 3'd0, 2'b00, 2'b01, 32'd0);
        tick();
        rbus.cfg_done = 1'b0;
        repeat (15) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        tick();
        chk("clr_wins_cnt", reconfig_cnt, 32'd0);

`ifdef PR_HRAV_DRAIN_TIMEOUT_EN
        // Core 0 never drains: timeout forces PRE after 32 DRAIN cycles
        core_busy = 2'b01; rbus.req_valid = 1'b1; rbus.req_core_id = 4'd0; n = cyc;
        push_exp(3'b001, n + 37, 3'd3, 2'b01, 2'b10, 32'd0);
        tick();
        rbus.req_valid = 1'b0;
        repeat (31) tick();
        chk("to_still_drain", {30'd0, drain_to, seq_state == 3'd1}, 32'h1);
        tick();
        chk("to_pre", {29'd0, seq_state}, 32'd2);
        chk("to_flag", {31'd0, drain_to}, 32'd1);
        wait_evt(0, 12);
        s = cyc;
        rbus.cfg_err = 1'b1;
        push_exp(3'b100, s + 2, 3'd0, 2'b01, 2'b10, 32'd0);
        tick();
        rbus.cfg_err = 1'b0; core_busy = 2'b00;
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("to_clear", {31'd0, drain_to}, 32'd0);
`endif

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
